// File: rtl/appmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : appmul_pkg
// Description : Shared types and default widths for the approximate-multiplier
//               recovery controller.
// Revision    : 1.0 - initial release
// ============================================================================
// Core invariant: core_p + core_err == exact product (mod 2^PW). Adding the
// error term back onto the approximate product therefore yields the exact
// product, and any carry out of the top chunk is discarded.
package appmul_pkg;

    localparam int c_OP_W  = 16;
    localparam int c_PW    = 2 * c_OP_W;
    localparam int c_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder
// Description : Holds the captured approximate product and error term and,
//               when started, adds them CHUNK bits per cycle (N cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder
    import appmul_pkg::*;
#(
    parameter int PW    = c_PW,
    parameter int CHUNK = c_CHUNK
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [PW-1:0] i_p,
    input  logic [PW-1:0] i_e,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [PW-1:0] o_p
);

    localparam int c_N     = PW / CHUNK;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    logic [PW-1:0]      r_p;
    logic [PW-1:0]      r_e;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_busy;
    logic [CHUNK:0]     w_sum;

    // Sum of the current chunk pair plus the carry from the previous chunk
    always_comb begin
        w_sum = {1'b0, r_p[r_idx*CHUNK +: CHUNK]}
              + {1'b0, r_e[r_idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, r_carry};
    end

    // Load captures the core outputs; while busy, one chunk is replaced per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_e     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
        end else if (i_load) begin
            r_p     <= i_p;
            r_e     <= i_e;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= i_start;
        end else if (r_busy) begin
            r_p[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            if (r_idx == c_LAST) begin
                // Final carry-out is dropped: the result is modulo 2^PW
                r_carry <= 1'b0;
                r_idx   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_carry <= w_sum[CHUNK];
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_idx == c_LAST);
    assign o_p    = r_p;

endmodule
`default_nettype wire

// File: rtl/appmul_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : appmul_recovery_ctrl
// Description : Sequences operand pairs through an external approximate
//               multiplier, optionally adds back its error term, returns the
//               result over valid/ready and counts non-zero error terms.
// Revision    : 1.0 - initial release
// ============================================================================
module appmul_recovery_ctrl
    import appmul_pkg::*;
#(
    parameter int OP_W     = c_OP_W,
    parameter int PW       = c_PW,
    parameter int CHUNK    = c_CHUNK,
    parameter int CORE_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_recover,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_p,
    output logic             out_recovered,
    output logic [OP_W-1:0]  core_a,
    output logic [OP_W-1:0]  core_b,
    input  logic [PW-1:0]    core_p,
    input  logic [PW-1:0]    core_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int c_WCNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WLOAD = c_WCNT_W'(CORE_LAT - 1);

    state_t              r_state;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_rec;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [PW-1:0]       r_out_p;
    logic                r_out_rec;
    logic [OP_W-1:0]     r_core_a;
    logic [OP_W-1:0]     r_core_b;
    logic [CNT_W-1:0]    r_err_cnt;

    logic                w_sample;
    logic                w_add_busy;
    logic                w_add_done;
    logic [PW-1:0]       w_add_p;

    // Core outputs are valid in the last wait cycle
    assign w_sample = (r_state == ST_WAIT) && (r_wcnt == '0);

    serial_chunk_adder #(
        .PW    (PW),
        .CHUNK (CHUNK)
    ) u_adder (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_sample),
        .i_p     (core_p),
        .i_e     (core_err),
        .i_start (r_rec),
        .o_busy  (w_add_busy),
        .o_done  (w_add_done),
        .o_p     (w_add_p)
    );

    // Operation sequencing and both handshakes, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wcnt      <= '0;
            r_rec       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_rec   <= 1'b0;
            r_core_a    <= '0;
            r_core_b    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_core_a   <= in_a;
                        r_core_b   <= in_b;
                        r_rec      <= in_recover;
                        r_wcnt     <= c_WLOAD;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_state <= r_rec ? ST_RECOVER : ST_DONE;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (w_add_done || !w_add_busy) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_p     <= w_add_p;
                        r_out_rec   <= r_rec;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of non-zero error terms; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_sample && (core_err != '0) && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_p         = r_out_p;
    assign out_recovered = r_out_rec;
    assign core_a        = r_core_a;
    assign core_b        = r_core_b;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/appmul_recovery_ctrl.md
Name: appmul_recovery_ctrl

Overview:
- Sequencing controller for the 16x16 approximate multiplier with error recovery.
- Accepts operand pairs over a valid/ready handshake and drives them to the external approximate-multiplier core.
- After the core latency, captures the core's approximate product and its error-recovery term. Optionally adds the two with a chunk-serial adder, then presents the result over an output valid/ready handshake.
- Keeps a saturating count of operations whose error term was non-zero.

Parameters:
- OP_W, 16, operand width.
- PW, 32, product/error width (2*OP_W).
- CHUNK, 8, bits added per cycle in recovery; PW must be a multiple of CHUNK; N = PW/CHUNK.
- CORE_LAT, 1, cycles from core operand change to valid core outputs; must be >= 1.
- CNT_W, 16, error-counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept.
- in_a  in  OP_W  multiplicand.
- in_b  in  OP_W  multiplier.
- in_recover  in  1  1 = return recovered (exact) product; 0 = approximate product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_p  out  PW  result product.
- out_recovered  out  1  echoes in_recover of this operation.
- core_a  out  OP_W  operand A to core.
- core_b  out  OP_W  operand B to core.
- core_p  in  PW  core approximate product.
- core_err  in  PW  core error-recovery term; core_p + core_err = exact product mod 2^PW.
- clr_cnt  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of operations with core_err != 0.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_p=0; out_recovered=0; core_a=core_b=0; err_cnt=0; internal p/e/carry/chunk-index registers cleared.
- States: IDLE, WAIT, RECOVER, DONE.
- in_ready is 1 only in IDLE (registered decode of state).

IDLE:
- On in_valid & in_ready: latch in_a/in_b into core_a/core_b, latch in_recover, load wait counter with CORE_LAT-1, go to WAIT.

WAIT:
- Decrement each cycle.
- In the cycle the counter is 0: sample core_p into p_reg and core_err into e_reg; update err_cnt.
- Next state: RECOVER if the latched recover bit is 1, else DONE.
- core_a/core_b hold their value until the next accept.

RECOVER:
- Cycle k (k=0..N-1): p_reg[k*CHUNK +: CHUNK] <= p_reg chunk + e_reg chunk + carry; carry <= chunk carry-out. Carry is 0 at k=0.
- The final carry-out is discarded (mod 2^PW).
- After chunk N-1, go to DONE.

DONE:
- out_valid=1; out_p=p_reg and out_recovered are stable while out_valid=1.
- On out_ready: go to IDLE; in_ready rises the next cycle. No same-cycle re-accept.

Latency:
- Accept edge to out_valid high = CORE_LAT+1 cycles when in_recover=0.
- Accept edge to out_valid high = CORE_LAT+1+N cycles when in_recover=1.
- Defaults: 2 / 6.

err_cnt:
- At the WAIT sample cycle, increments if core_err != 0.
- Saturates at all-ones.
- clr_cnt sets it to 0; clr_cnt in the same cycle as an increment → 0.

Other rules:
- in_valid while not in IDLE is ignored; the requester must hold it.
- in_a/in_b changes after accept have no effect.
- rst_n low mid-operation aborts the operation immediately to reset values; no output is produced for it.
- out_ready outside DONE is ignored.

Decomposition:
- Shared package appmul_pkg:
  - state enum (IDLE, WAIT, RECOVER, DONE);
  - default widths OP_W/PW/CHUNK;
  - the invariant note for core_p + core_err.
- One sub-module: serial_chunk_adder. It holds p_reg, e_reg, carry and the chunk index, has a start/busy/done interface, and takes N cycles.
- The FSM, counters and handshake live in the top module.

Test Plan:
- Bench core model: core_p = exact with low 4 bits cleared, core_err = exact & 0xF. Send a=3, b=5, recover=0 → out_p=0x00000000 after 2 cycles, out_recovered=0, err_cnt=1.
- Same model, a=3, b=5, recover=1 → out_p=0x0000000F exactly 6 cycles after accept; err_cnt=2.
- Carry chain: bench forces core_p=0x00FFFFFF, core_err=0x00000001, recover=1 → out_p=0x01000000. Also core_p=0xFFFFFFFF, core_err=1 → 0x00000000 (wrap).
- Backpressure: out_ready=0 for 5 cycles in DONE → out_p/out_valid stable, in_ready=0, a second in_valid is not accepted. out_ready=1 → IDLE, in_ready=1 the next cycle, the queued request is accepted.
- Counter: preload by 0xFFFF error operations → err_cnt=0xFFFF and it stays there on the next error. Assert clr_cnt in the same cycle as an error sample → err_cnt=0.
- Reset mid-RECOVER: assert rst_n=0 at chunk 2 → all outputs take reset values asynchronously. After release, a=0x00FF, b=0x0101, recover=1 → out_p=0x0000FFFF.
